// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter front end.
//   W, SELW, NREQ : datapath width, operation-select width, requester count
//   alu_op_e      : ALU_Sel encodings understood by alu
//   rsp_t         : registered response bundle {id, result, carry, zero}
package alu_pkg;
  localparam int W    = 32;
  localparam int SELW = 4;
  localparam int NREQ = 2;

  typedef enum logic [SELW-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
  } rsp_t;
endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU.
//   A, B     : operands
//   ALU_Sel  : operation (alu_op_e); unused codes yield 0
//   ALU_Out  : result
//   CarryOut : ADD carry-out of bit 31; SUB no-borrow (A >= B unsigned); else 0
//   ZeroOut  : ALU_Out == 0
module alu
  import alu_pkg::*;
(
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  input  logic [SELW-1:0] ALU_Sel,
  output logic [W-1:0]    ALU_Out,
  output logic            CarryOut,
  output logic            ZeroOut
);
  logic [W:0]           sum;
  logic [$clog2(W)-1:0] shamt;

  assign shamt = B[$clog2(W)-1:0];

  always_comb begin
    sum      = '0;
    ALU_Out  = '0;
    CarryOut = 1'b0;
    case (ALU_Sel)
      ALU_ADD: begin
        sum      = {1'b0, A} + {1'b0, B};
        ALU_Out  = sum[W-1:0];
        CarryOut = sum[W];
      end
      ALU_SUB: begin
        // A + ~B + 1: carry set means no borrow
        sum      = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
        ALU_Out  = sum[W-1:0];
        CarryOut = sum[W];
      end
      ALU_SLL:   ALU_Out = A << shamt;
      ALU_SLT:   ALU_Out = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLTU:  ALU_Out = {{(W-1){1'b0}}, A < B};
      ALU_XOR:   ALU_Out = A ^ B;
      ALU_SRL:   ALU_Out = A >> shamt;
      ALU_SRA:   ALU_Out = $unsigned($signed(A) >>> shamt);
      ALU_OR:    ALU_Out = A | B;
      ALU_AND:   ALU_Out = A & B;
      ALU_PASSB: ALU_Out = B;
      default:   ALU_Out = '0;
    endcase
  end

  assign ZeroOut = (ALU_Out == '0);
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
//   valid    : request valid per requester
//   prio     : requester favoured on contention
//   en       : grant enable (downstream can accept)
//   gnt      : one-hot or zero grant
//   prio_nxt : pointer after this cycle (loser of a grant gets priority)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       prio_nxt
);
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&valid) gnt = prio ? 2'b10 : 2'b01;
      else        gnt = valid;
    end
  end

  // A grant to i hands priority to the other requester
  always_comb begin
    prio_nxt = prio;
    if (gnt[0])      prio_nxt = 1'b1;
    else if (gnt[1]) prio_nxt = 1'b0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between the execute stage (port 0) and the branch/compare
// unit (port 1). One round-robin grant per cycle; the result lands in a
// registered, ID-tagged response slot with valid/ready backpressure.
//   clk, rst_n              : clock, async active-low reset
//   req_valid / req_ready   : per-requester handshake (bit i = requester i)
//   req_a0/b0/sel0          : requester 0 operation
//   req_a1/b1/sel1          : requester 1 operation
//   rsp_valid / rsp_ready   : response handshake
//   rsp_id, rsp_result, rsp_carry, rsp_zero : registered response
module alu_arbiter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [W-1:0]    req_a0,
  input  logic [W-1:0]    req_b0,
  input  logic [SELW-1:0] req_sel0,
  input  logic [W-1:0]    req_a1,
  input  logic [W-1:0]    req_b1,
  input  logic [SELW-1:0] req_sel1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [W-1:0]    rsp_result,
  output logic            rsp_carry,
  output logic            rsp_zero
);
  logic            prio, prio_nxt;
  logic            can_accept;
  logic [1:0]      gnt;
  logic            sel1;
  logic [W-1:0]    alu_a, alu_b, alu_out;
  logic [SELW-1:0] alu_sel;
  logic            alu_carry, alu_zero;
  rsp_t            rsp_q;

  // A draining slot may be refilled in the same cycle
  assign can_accept = !rsp_valid || rsp_ready;

  rr_arb2 u_arb (
    .valid    (req_valid),
    .prio     (prio),
    .en       (can_accept && rst_n),
    .gnt      (gnt),
    .prio_nxt (prio_nxt)
  );

  assign req_ready = gnt;

  // Idle mux parks on the priority requester
  assign sel1    = gnt[1] || (!gnt[0] && prio);
  assign alu_a   = sel1 ? req_a1   : req_a0;
  assign alu_b   = sel1 ? req_b1   : req_b0;
  assign alu_sel = sel1 ? req_sel1 : req_sel0;

  alu u_alu (alu_a, alu_b, alu_sel, alu_out, alu_carry, alu_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      prio      <= 1'b0;
    end else begin
      prio <= prio_nxt;
      if (|gnt) begin
        rsp_valid <= 1'b1;
        rsp_q     <= '{id: gnt[1], result: alu_out, carry: alu_carry, zero: alu_zero};
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_carry  = rsp_q.carry;
  assign rsp_zero   = rsp_q.zero;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level model checked on
// every falling edge, plus directed vectors with literal expectations.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [3:0]  req_sel0 = '0, req_sel1 = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_carry, rsp_zero;
  logic [31:0] rsp_result;

  int vectors = 0;
  int miscompares = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
    .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the operation definitions
  function automatic logic [33:0] ref_alu(input logic [31:0] a, b, input logic [3:0] sel);
    logic [31:0] r;
    logic        c;
    longint unsigned s;
    r = 0; c = 0;
    case (sel)
      4'd0: begin s = longint'(a) + longint'(b); r = a + b; c = s > 64'hFFFF_FFFF; end
      4'd1: begin r = a - b; c = (a >= b); end
      4'd2: r = a << b[4:0];
      4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> b[4:0];
      4'd7: r = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: r = b;
      default: r = 0;
    endcase
    return {c, (r == 0), r};
  endfunction

  // Model state: pending response slot and whose turn it is on contention
  logic        m_valid = 0, m_prio = 0, m_id = 0, m_carry = 0, m_zero = 0;
  logic [31:0] m_result = 0;

  function automatic int m_grant();
    if (!rst_n) return -1;
    if (m_valid && !rsp_ready) return -1;
    if (req_valid == 2'b11) return m_prio ? 1 : 0;
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_prio <= 0;
    end else begin
      int g;
      logic [33:0] r;
      g = m_grant();
      if (g == 0) r = ref_alu(req_a0, req_b0, req_sel0);
      else        r = ref_alu(req_a1, req_b1, req_sel1);
      if (g >= 0) begin
        m_valid <= 1; m_id <= g[0]; m_prio <= ~g[0];
        m_result <= r[31:0]; m_zero <= r[32]; m_carry <= r[33];
      end else if (rsp_ready) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    g = m_grant();
    chk("req_ready", 64'(req_ready), (g == 0) ? 64'd1 : (g == 1) ? 64'd2 : 64'd0);
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_result", 64'(rsp_result), 64'(m_result));
      chk("rsp_carry", 64'(rsp_carry), 64'(m_carry));
      chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [31:0] exp_tab [16] = '{32'd10, 32'd0, 32'd160, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                32'd5, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] snap_res;
  logic        snap_id, snap_zero;

  initial begin
    // Reset: requests asserted must not be granted
    req_valid = 2'b11;
    repeat (3) step();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_carry", 64'(rsp_carry), 64'd0);
    chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // 1: single request from port 0
    req_a0 = 5; req_b0 = 5; req_sel0 = 4'd0; req_valid = 2'b01; rsp_ready = 1;
    #1 chk("t1_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_result", 64'(rsp_result), 64'd10);
    chk("t1_zero", 64'(rsp_zero), 64'd0);

    // Port 1 alone, hands priority back to port 0
    req_a1 = 5; req_b1 = 5; req_sel1 = 4'd1; req_valid = 2'b10;
    step();

    // 2: contention alternates 0,1,0,1
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_ready", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      step();
      chk("t2_id", 64'(rsp_id), 64'(k % 2));
      chk("t2_result", 64'(rsp_result), (k % 2 == 0) ? 64'd10 : 64'd0);
      chk("t2_zero", 64'(rsp_zero), 64'(k % 2));
    end

    // 3: backpressure holds the slot and blocks grants
    rsp_ready = 0;
    snap_res = rsp_result; snap_id = rsp_id; snap_zero = rsp_zero;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_ready", 64'(req_ready), 64'd0);
      step();
      chk("t3_valid", 64'(rsp_valid), 64'd1);
      chk("t3_hold_res", 64'(rsp_result), 64'(snap_res));
      chk("t3_hold_id", 64'(rsp_id), 64'(snap_id));
      chk("t3_hold_zero", 64'(rsp_zero), 64'(snap_zero));
    end
    rsp_ready = 1;
    #1 chk("t3_regrant", 64'(req_ready), 64'd1);
    step();
    chk("t3_id", 64'(rsp_id), 64'd0);
    chk("t3_result", 64'(rsp_result), 64'd10);

    // 4: 16 back-to-back port-1 ops, every select code
    req_valid = 2'b10;
    for (int s = 0; s < 16; s++) begin
      req_sel1 = 4'(s);
      #1 chk("t4_ready", 64'(req_ready), 64'd2);
      step();
      chk("t4_valid", 64'(rsp_valid), 64'd1);
      chk("t4_id", 64'(rsp_id), 64'd1);
      chk("t4_result", 64'(rsp_result), 64'(exp_tab[s]));
    end
    req_valid = 2'b00;
    step();
    chk("t4_drain", 64'(rsp_valid), 64'd0);

    // 5: reset while a response is stalled
    req_sel1 = 4'd1; req_valid = 2'b11; rsp_ready = 0;
    step();
    chk("t5_valid", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_clr", 64'(rsp_valid), 64'd0);
    chk("t5_rst_ready", 64'(req_ready), 64'd0);
    step();
    rst_n = 1'b1; rsp_ready = 1;
    #1 chk("t5_first_gnt", 64'(req_ready), 64'd1);
    step();
    chk("t5_id", 64'(rsp_id), 64'd0);

    // 6: lone port 1 gets every cycle
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t6_ready", 64'(req_ready), 64'd2);
      step();
      chk("t6_valid", 64'(rsp_valid), 64'd1);
      chk("t6_id", 64'(rsp_id), 64'd1);
      chk("t6_result", 64'(rsp_result), 64'd0);
    end
    req_valid = 2'b00;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
